dmem_arbiter: RTL and testbench

Two-requester arbiter for the single-port data memory (16 words) shared by the CPU controller and the external console loader (switches/push-buttons). It accepts one read or write per transaction, grants round-robin, and drives the memory port. It returns read data with a valid pulse to the winning requester. It sits between both masters and the data memory; neither master drives the memory directly.

---
 rtl/dmem_arb_pkg.sv | 17 +
 rtl/rr_pick2.sv | 25 ++
 rtl/dmem_arbiter.sv | 134 +++++++++++++
 tb/tb_dmem_arbiter.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter and its tie-break helper.
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    // Requester indices into req/we/gnt/rvalid
    localparam logic REQ_CPU = 1'b0;
    localparam logic REQ_CON = 1'b1;

    // Conflict counter ceiling; the counter holds here instead of wrapping
    localparam logic [7:0] CONFLICT_MAX = 8'hFF;

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin pick. A lone requester always wins; on a tie the
// requester that did not win last time gets the slot. Kept separate so the
// same tie-break can be reused for other two-master resources.
module rr_pick2
    import dmem_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_owner,
    output logic       valid,
    output logic       winner
);

    // Winner selection: single requester wins outright, tie alternates
    always_comb begin
        valid  = |req;
        winner = REQ_CPU;
        case (req)
            2'b01:   winner = REQ_CPU;
            2'b10:   winner = REQ_CON;
            2'b11:   winner = ~last_owner;
            default: winner = REQ_CPU;
        endcase
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Arbiter between the CPU controller and the console loader for the
// single-port data memory. One transaction at a time: IDLE picks a winner and
// latches its request, ACCESS drives the memory port, RESP (reads only)
// returns the memory output to the owner.
//
// Handshake: a requester raises req[i] with we/addr/wdata stable and holds
// them until it samples gnt[i] high on a rising edge; it drops req on that
// same edge. Requests are only looked at in IDLE, so anything still high in
// the following IDLE is a brand-new request. A read answers with a one-cycle
// rvalid[i] pulse, with rdata valid in that cycle, one cycle after gnt[i].
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        req,
    input  logic [1:0]        we,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic [1:0]        gnt,
    output logic [1:0]        rvalid,
    output logic [DATA_W-1:0] rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic [7:0]        conflicts
);

    state_t              state;
    state_t              state_next;
    logic                owner_q;
    logic                we_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic                last_owner_q;
    logic [7:0]          conflicts_q;
    logic                pick_valid;
    logic                pick_winner;
    logic                take;

    rr_pick2 u_pick (
        .req        (req),
        .last_owner (last_owner_q),
        .valid      (pick_valid),
        .winner     (pick_winner)
    );

    assign take = (state == IDLE) && pick_valid;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state: writes finish after ACCESS, reads need the extra RESP cycle
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    state_next = pick_valid ? ACCESS : IDLE;
            ACCESS:  state_next = we_q ? IDLE : RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Capture the winning request so outputs never depend on live inputs
    always_ff @(posedge clk) begin
        if (reset) begin
            owner_q      <= REQ_CPU;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            last_owner_q <= REQ_CON;
        end else if (take) begin
            owner_q      <= pick_winner;
            we_q         <= we[pick_winner];
            addr_q       <= pick_winner ? addr1 : addr0;
            wdata_q      <= pick_winner ? wdata1 : wdata0;
            last_owner_q <= pick_winner;
        end
    end

    // Count IDLE cycles where both masters want the memory, holding at max
    always_ff @(posedge clk) begin
        if (reset) begin
            conflicts_q <= '0;
        end else if ((state == IDLE) && (req == 2'b11) && (conflicts_q != CONFLICT_MAX)) begin
            conflicts_q <= conflicts_q + 8'd1;
        end
    end

    // Output decode from registered state and latches only
    always_comb begin
        gnt       = 2'b00;
        rvalid    = 2'b00;
        rdata     = '0;
        mem_addr  = '0;
        mem_rd    = 1'b0;
        mem_wr    = 1'b0;
        mem_wdata = '0;
        busy      = (state != IDLE);
        conflicts = conflicts_q;
        case (state)
            ACCESS: begin
                gnt[owner_q] = 1'b1;
                mem_addr     = addr_q;
                if (we_q) begin
                    mem_wr    = 1'b1;
                    mem_wdata = wdata_q;
                end else begin
                    mem_rd = 1'b1;
                end
            end
            RESP: begin
                rvalid[owner_q] = 1'b1;
                rdata           = mem_rdata;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: a 16x8 memory, a transaction-level schedule model
// that predicts every output each cycle, and directed tests with literal
// expectations.
module tb_dmem_arbiter;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] req = 2'b00;
    logic [1:0] we = 2'b00;
    logic [3:0] addr0 = '0;
    logic [3:0] addr1 = '0;
    logic [7:0] wdata0 = '0;
    logic [7:0] wdata1 = '0;
    logic [1:0] gnt;
    logic [1:0] rvalid;
    logic [7:0] rdata;
    logic [3:0] mem_addr;
    logic       mem_rd;
    logic       mem_wr;
    logic [7:0] mem_wdata;
    logic [7:0] mem_rdata = '0;
    logic       busy;
    logic [7:0] conflicts;

    int total = 0;
    int bad = 0;

    dmem_arbiter #(.ADDR_W(4), .DATA_W(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .we        (we),
        .addr0     (addr0),
        .addr1     (addr1),
        .wdata0    (wdata0),
        .wdata1    (wdata1),
        .gnt       (gnt),
        .rvalid    (rvalid),
        .rdata     (rdata),
        .mem_addr  (mem_addr),
        .mem_rd    (mem_rd),
        .mem_wr    (mem_wr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .busy      (busy),
        .conflicts (conflicts)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- memory ----------------
    logic [7:0] mem [16];
    logic [7:0] model_mem [16];

    always @(posedge clk) begin
        if (mem_wr) mem[mem_addr] <= mem_wdata;
        if (mem_rd) mem_rdata <= mem[mem_addr];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- model ----------------
    // Expected output picture for one cycle.
    typedef struct packed {
        logic [1:0] gnt;
        logic [1:0] rvalid;
        logic [7:0] rdata;
        logic [3:0] addr;
        logic       rd;
        logic       wr;
        logic [7:0] wdata;
        logic       busy;
    } exp_t;

    exp_t m_cur = '0;
    exp_t m_next = '0;
    int   m_conf = 0;
    logic m_last = 1'b1;
    bit   started = 0;

    // A transaction occupies the memory for one cycle (write) or two (read)
    // starting the cycle after it is seen; a new one is accepted only when the
    // current cycle carries no transaction.
    always @(posedge clk) begin
        exp_t nc;
        logic w;
        logic [3:0] a;
        if (reset) begin
            m_cur = '0;
            m_next = '0;
            m_conf = 0;
            m_last = 1'b1;
            started = 1;
        end else begin
            nc = m_next;
            m_next = '0;
            if (!m_cur.busy && req != 2'b00) begin
                if (req == 2'b11) begin
                    if (m_conf < 255) m_conf = m_conf + 1;
                    w = ~m_last;
                end else begin
                    w = req[1];
                end
                m_last = w;
                a = w ? addr1 : addr0;
                nc = '0;
                nc.gnt = 2'b01 << w;
                nc.addr = a;
                nc.busy = 1'b1;
                if (we[w]) begin
                    nc.wr = 1'b1;
                    nc.wdata = w ? wdata1 : wdata0;
                    model_mem[a] = nc.wdata;
                end else begin
                    nc.rd = 1'b1;
                    m_next.busy = 1'b1;
                    m_next.rvalid = 2'b01 << w;
                    m_next.rdata = model_mem[a];
                end
            end
            m_cur = nc;
        end
    end

    // ---------------- per-cycle compare ----------------
    logic [1:0] gnt_log[$];

    always @(negedge clk) begin
        if (started) begin
            chk("gnt", gnt, m_cur.gnt);
            chk("rvalid", rvalid, m_cur.rvalid);
            chk("rdata", rdata, m_cur.rdata);
            chk("mem_addr", mem_addr, m_cur.addr);
            chk("mem_rd", mem_rd, m_cur.rd);
            chk("mem_wr", mem_wr, m_cur.wr);
            chk("mem_wdata", mem_wdata, m_cur.wdata);
            chk("busy", busy, m_cur.busy);
            chk("conflicts", conflicts, m_conf);
            chk("rd_wr_excl", mem_rd & mem_wr, 1'b0);
            chk("gnt_rvalid_excl", (|gnt) & (|rvalid), 1'b0);
            if (gnt != 2'b00) gnt_log.push_back(gnt);
        end
    end

    // ---------------- driver helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_gnt"}, gnt, 2'b00);
        chk({tag, "_rvalid"}, rvalid, 2'b00);
        chk({tag, "_rdata"}, rdata, 8'h00);
        chk({tag, "_mem_rd"}, mem_rd, 1'b0);
        chk({tag, "_mem_wr"}, mem_wr, 1'b0);
        chk({tag, "_mem_addr"}, mem_addr, 4'h0);
        chk({tag, "_busy"}, busy, 1'b0);
        chk({tag, "_conflicts"}, conflicts, 8'h00);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [1:0] exp_q[$];
        int n;
        for (int i = 0; i < 16; i++) begin
            mem[i] = 8'(i * 17);
            model_mem[i] = 8'(i * 17);
        end
        mem[7] = 8'h3C;
        model_mem[7] = 8'h3C;

        // Reset
        tick();
        tick();
        reset = 1'b0;
        check_all_zero("reset");

        // CPU write A5 to address 3
        req = 2'b01; we = 2'b01; addr0 = 4'd3; wdata0 = 8'hA5;
        tick();
        chk("wr_gnt", gnt, 2'b01);
        chk("wr_mem_wr", mem_wr, 1'b1);
        chk("wr_mem_addr", mem_addr, 4'd3);
        chk("wr_mem_wdata", mem_wdata, 8'hA5);
        tick();
        req = 2'b00;
        chk("wr_busy_after", busy, 1'b0);

        // Console read of preloaded address 7
        req = 2'b10; we = 2'b00; addr1 = 4'd7;
        tick();
        chk("rd_gnt", gnt, 2'b10);
        chk("rd_mem_rd", mem_rd, 1'b1);
        chk("rd_mem_addr", mem_addr, 4'd7);
        tick();
        req = 2'b00;
        chk("rd_rvalid", rvalid, 2'b10);
        chk("rd_rdata", rdata, 8'h3C);
        chk("rd_gnt_in_resp", gnt, 2'b00);
        tick();
        chk("rd_busy_after", busy, 1'b0);

        // CPU read of address 3, console write arrives during RESP
        req = 2'b01; we = 2'b00; addr0 = 4'd3;
        tick();
        chk("ov_cpu_gnt", gnt, 2'b01);
        tick();
        req = 2'b10; we = 2'b10; addr1 = 4'd9; wdata1 = 8'h5A;
        chk("ov_rvalid", rvalid, 2'b01);
        chk("ov_rdata", rdata, 8'hA5);
        chk("ov_con_gnt_early", gnt, 2'b00);
        tick();
        chk("ov_idle_gnt", gnt, 2'b00);
        chk("ov_idle_busy", busy, 1'b0);
        tick();
        chk("ov_con_gnt", gnt, 2'b10);
        chk("ov_con_wr", mem_wr, 1'b1);
        chk("ov_con_addr", mem_addr, 4'd9);
        tick();
        req = 2'b00;

        // Both requesters held high for four write transactions
        gnt_log.delete();
        exp_q = '{2'b01, 2'b10, 2'b01, 2'b10};
        req = 2'b11; we = 2'b11; addr0 = 4'd10; wdata0 = 8'h10; addr1 = 4'd12; wdata1 = 8'h21;
        n = 0;
        for (int i = 0; i < 40 && n < 4; i++) begin
            tick();
            if (gnt != 2'b00) n++;
        end
        req = 2'b00;
        chk("rr_grant_count", n, 4);
        tick();
        tick();
        chk("rr_conflicts", conflicts, 8'd4);
        chk("rr_log_size", gnt_log.size(), 4);
        for (int i = 0; i < 4 && i < gnt_log.size(); i++) begin
            chk("rr_order", gnt_log[i], exp_q[i]);
        end

        // Reset landing in the ACCESS cycle of a read
        req = 2'b01; we = 2'b00; addr0 = 4'd5;
        tick();
        chk("ab_gnt", gnt, 2'b01);
        chk("ab_mem_rd", mem_rd, 1'b1);
        req = 2'b00;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_all_zero("abort");
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("ab_no_rvalid", rvalid, 2'b00);
        end

        // Saturation of the conflict counter
        req = 2'b11; we = 2'b11; addr0 = 4'd1; wdata0 = 8'h11; addr1 = 4'd2; wdata1 = 8'h22;
        repeat (200) @(posedge clk);
        #1;
        chk("sat_mid", conflicts, 8'd100);
        repeat (400) @(posedge clk);
        #1;
        chk("sat_max", conflicts, 8'd255);
        repeat (40) @(posedge clk);
        #1;
        chk("sat_hold", conflicts, 8'd255);
        req = 2'b00;
        tick();
        tick();
        chk("sat_idle_busy", busy, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Run bound
    initial begin
        #200000;
        $display("FAIL watchdog: run did not finish");
        $fatal(1, "watchdog expired");
    end

endmodule
